// File: rtl/pll_rst_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer: FSM state encoding,
// registered-output bundle and the retry-count saturating increment.
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int DEF_RST_PULSE_CYC    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = 65535;
  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_MAX_RETRY        = 7;

  localparam logic [3:0] RETRY_SAT = 4'hF;

  typedef struct packed {
    logic pll_rst;
    logic rst_out;
    logic seq_ready;
    logic seq_fail;
  } seq_out_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == RETRY_SAT) ? v : v + 4'd1;
  endfunction

  // Output levels that hold for the whole time the FSM sits in a state.
  function automatic seq_out_t state_out(input state_t s);
    seq_out_t o;
    o = '0;
    case (s)
      RESET:     begin o.pll_rst = 1'b1; o.rst_out = 1'b1; end
      WAIT_LOCK: o.rst_out = 1'b1;
      STABLE:    o.rst_out = 1'b1;
      RUN:       o.seq_ready = 1'b1;
      FAIL:      begin o.pll_rst = 1'b1; o.rst_out = 1'b1; o.seq_fail = 1'b1; end
      default:   begin o.pll_rst = 1'b1; o.rst_out = 1'b1; end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pll_rst_seq_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops clear to 0
// on the synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock, then
// releases downstream reset. Optional loss-of-lock counter: PLL_RST_SEQ_LOL_CNT_EN.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_rst,
  output logic       rst_out,
  output logic       seq_ready,
  output logic       seq_fail,
  output logic       lol_pulse,
  output logic [3:0] retry_cnt,
  output logic [7:0] lol_cnt
);

  localparam int PW = $clog2(RST_PULSE_CYC + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYC + 1);

  localparam logic [PW-1:0] PULSE_LAST   = PW'(RST_PULSE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

  state_t        r_state;
  logic [PW-1:0] r_pulse_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [SW-1:0] r_stable_cnt;
  logic [3:0]    r_retry_cnt;
  logic          r_pll_rst;
  logic          r_rst_out;
  logic          r_seq_ready;
  logic          r_seq_fail;
  logic          r_lol_pulse;

  state_t        w_state_next;
  logic          w_lock_s;
  logic          w_timeout;
  logic          w_hold;
  logic          w_lol_event;
  logic [3:0]    w_retry_inc;
  seq_out_t      w_out;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_lock),
    .o_q (w_lock_s)
  );

  assign w_timeout   = (r_state == WAIT_LOCK) && !w_lock_s && (r_to_cnt == TIMEOUT_LAST);
  assign w_lol_event = (r_state == RUN) && !w_lock_s;
  assign w_retry_inc = sat_inc4(r_retry_cnt);

  always_comb begin
    w_state_next = r_state;
    if (restart) begin
      w_state_next = RESET;
    end else begin
      case (r_state)
        RESET:     if (r_pulse_cnt == PULSE_LAST) w_state_next = WAIT_LOCK;
        WAIT_LOCK: begin
          if (w_lock_s)       w_state_next = STABLE;
          else if (w_timeout) w_state_next = (w_retry_inc == RETRY_LIMIT) ? FAIL : RESET;
        end
        STABLE: begin
          if (!w_lock_s)                         w_state_next = WAIT_LOCK;
          else if (r_stable_cnt == STABLE_LAST)  w_state_next = RUN;
        end
        RUN:       if (!w_lock_s) w_state_next = RESET;
        FAIL:      w_state_next = FAIL;
        default:   w_state_next = RESET;
      endcase
    end
  end

  // A counter only advances while its state is held; any transition or restart zeroes it.
  assign w_hold = !restart && (w_state_next == r_state);
  assign w_out  = state_out(w_state_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RESET;
      r_pulse_cnt  <= '0;
      r_to_cnt     <= '0;
      r_stable_cnt <= '0;
      r_retry_cnt  <= '0;
      r_pll_rst    <= 1'b1;
      r_rst_out    <= 1'b1;
      r_seq_ready  <= 1'b0;
      r_seq_fail   <= 1'b0;
      r_lol_pulse  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pulse_cnt  <= (w_hold && r_state == RESET)     ? r_pulse_cnt + PW'(1)  : '0;
      r_to_cnt     <= (w_hold && r_state == WAIT_LOCK) ? r_to_cnt + TW'(1)     : '0;
      r_stable_cnt <= (w_hold && r_state == STABLE)    ? r_stable_cnt + SW'(1) : '0;
      if (restart || (w_state_next == RUN && r_state != RUN)) begin
        r_retry_cnt <= '0;
      end else if (w_timeout) begin
        r_retry_cnt <= w_retry_inc;
      end
      r_pll_rst    <= w_out.pll_rst;
      r_rst_out    <= w_out.rst_out;
      r_seq_ready  <= w_out.seq_ready;
      r_seq_fail   <= w_out.seq_fail;
      r_lol_pulse  <= w_lol_event;
    end
  end

`ifdef PLL_RST_SEQ_LOL_CNT_EN
  logic [7:0] r_lol_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lol_cnt <= '0;
    end else if (w_lol_event && r_lol_cnt != 8'hFF) begin
      r_lol_cnt <= r_lol_cnt + 8'd1;
    end
  end

  assign lol_cnt = r_lol_cnt;
`else
  assign lol_cnt = '0;
`endif

  assign pll_rst   = r_pll_rst;
  assign rst_out   = r_rst_out;
  assign seq_ready = r_seq_ready;
  assign seq_fail  = r_seq_fail;
  assign lol_pulse = r_lol_pulse;
  assign retry_cnt = r_retry_cnt;

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 Parameter RST_PULSE_CYC, default 16: width of the pll_rst pulse, in clk cycles (legal range 2..255).
REQ-002 Parameter LOCK_TIMEOUT_CYC, default 65535: maximum clk cycles to wait for lock after pll_rst is released.
REQ-003 Parameter LOCK_STABLE_CYC, default 1024: number of consecutive cycles with lock high required before downstream release.
REQ-004 Parameter MAX_RETRY, default 7: number of consecutive lock timeouts that moves the block to FAIL (legal range 1..15).
REQ-005 Ports:
- clk  in  1: free-running PLL reference clock (same net as the PLL clkin1).
- rst  in  1: synchronous, active-high reset.
- pll_lock  in  1: PLL lock; asynchronous to clk.
- restart  in  1: one-cycle request to re-run the sequence.
- pll_rst  out  1: reset to the PLL; active high.
- rst_out  out  1: reset for the PLL-clocked logic; active high.
- seq_ready  out  1: high only in state RUN.
- seq_fail  out  1: high only in state FAIL.
- lol_pulse  out  1: one-cycle pulse on each loss of lock seen in RUN.
- retry_cnt  out  4: count of consecutive lock timeouts.
- lol_cnt  out  8: number of loss-of-lock events.

Function
REQ-006 pll_lock shall pass through a two-flop synchronizer; lock_s is the synchronizer output, which lags pll_lock by 2 cycles.
REQ-007 FSM states shall be RESET, WAIT_LOCK, STABLE, RUN and FAIL. All outputs shall be registered.
REQ-008 RESET: pll_rst=1 and rst_out=1; a counter runs for RST_PULSE_CYC cycles, then the FSM goes to WAIT_LOCK.
REQ-009 WAIT_LOCK: pll_rst=0 and rst_out=1; the timeout counter increments each cycle.
- If lock_s=1, go to STABLE.
- If the counter reaches LOCK_TIMEOUT_CYC-1 with lock_s=0, increment retry_cnt, then go to FAIL if the new value equals MAX_RETRY, otherwise go to RESET.
REQ-010 STABLE: rst_out=1; the stable counter increments while lock_s=1.
- If lock_s=0, clear the counter and go to WAIT_LOCK, with the timeout counter restarted from 0.
- If the count reaches LOCK_STABLE_CYC-1 with lock_s=1, go to RUN.
REQ-011 On entry to RUN: rst_out=0, seq_ready=1 and retry_cnt cleared; RUN holds while lock_s=1.
REQ-012 RUN, lock_s=0 in cycle N: in cycle N+1, lol_pulse=1, rst_out=1, seq_ready=0 and state=RESET; no glitch is permitted.
REQ-013 FAIL: pll_rst=1, rst_out=1 and seq_fail=1; the FSM stays in FAIL until restart or rst.
REQ-014 restart=1 in any state: next state is RESET, all counters cleared, retry_cnt=0 (lol_cnt is not cleared).
REQ-015 If restart=1 and a lock loss occur in the same cycle, restart has priority; lol_pulse still fires if the FSM was in RUN.
REQ-016 Counter widths shall be $clog2(param+1); no counter may wrap; retry_cnt shall saturate at 15.

Reset
REQ-017 rst=1 shall force state=RESET and all counters to 0, with outputs pll_rst=1, rst_out=1, seq_ready=0, seq_fail=0, lol_pulse=0, retry_cnt=0, lol_cnt=0.
REQ-018 rst has priority over restart and over lock_s.
REQ-019 rst asserted mid-pulse shall restart the full RST_PULSE_CYC pulse from count 0.
REQ-020 The synchronizer flops shall reset to 0.

Configuration
REQ-021 Macro PLL_RST_SEQ_LOL_CNT_EN:
- Defined: lol_cnt increments on each lol_pulse and saturates at 255.
- Undefined: lol_cnt is tied to 0 and no counter flops are present.

Structure
REQ-022 Package pll_rst_seq_pkg shall hold the state typedef (RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4) and the default parameter constants.
REQ-023 Sub-module sync_2ff (1-bit, reset value 0) shall implement the lock synchronizer.

Verification
Bench parameters: RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=100, LOCK_STABLE_CYC=20, MAX_RETRY=3.
REQ-024 Normal lock:
- rst for 2 cycles, pll_lock rises 10 cycles after pll_rst falls.
- Required: pll_rst high for exactly 4 cycles; rst_out falls 2+20 cycles after the pll_lock rise (±1 for the synchronizer); seq_ready=1.
REQ-025 Chatter: lock pulses high for 5 cycles, then low, then high.
- Required: STABLE is abandoned and rst_out stays 1.
- Release occurs 20 cycles after the final rise.
REQ-026 Timeouts: pll_lock held at 0.
- Required: three pll_rst pulses, retry_cnt steps 1,2,3, seq_fail=1 after the third timeout, pll_rst held at 1.
- A restart pulse then gives seq_fail=0, retry_cnt=0 and a new pll_rst pulse.
REQ-027 Loss in RUN: pll_lock drops for 1 cycle.
- Required: exactly one lol_pulse; rst_out=1 two to three cycles later; lol_cnt=1 with the macro defined, 0 without.
REQ-028 Reset mid-operation: rst asserted in STABLE at stable count 15, and separately at RESET count 2.
- Required: full 4-cycle pll_rst pulse restarts; no early rst_out release.
